mem_port_arbiter: RTL and testbench

//   Shares the single data-memory port (MIPS_RAM in the MEM stage) between the pipeline MEM stage (CPU) and a DMA/loader master.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the MEM-stage data RAM port: CPU priority with a DMA starvation guard.
// Optional MEM_ARB_STATS_EN adds stall-cycle and DMA-transfer counters.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_byte,
  input  logic        cpu_half,
  input  logic        cpu_uext,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_byte,
  input  logic        dma_half,
  input  logic        dma_uext,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_byte,
  output logic        ram_half,
  output logic        ram_uext,
  input  logic [31:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_dma
`endif
);

  typedef enum logic {CPU_PRI, DMA_FORCE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_nxt;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!CLR) begin
      case (state)
        CPU_PRI: begin
          cpu_gnt = cpu_req;
          dma_gnt = dma_req & ~cpu_req;
        end
        DMA_FORCE: begin
          dma_gnt = dma_req;
        end
        default: begin
          cpu_gnt = 1'b0;
          dma_gnt = 1'b0;
        end
      endcase
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_byte  = 1'b0;
    ram_half  = 1'b0;
    ram_uext  = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      ram_byte  = cpu_byte;
      ram_half  = cpu_half;
      ram_uext  = cpu_uext;
    end else if (dma_gnt) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
      ram_byte  = dma_byte;
      ram_half  = dma_half;
      ram_uext  = dma_uext;
    end
  end

  // Wait counter saturates so a long CPU burst cannot wrap it past the limit.
  always_comb begin
    wcnt_nxt = wcnt;
    if (!dma_req || dma_gnt)
      wcnt_nxt = '0;
    else if (wcnt < LIMIT)
      wcnt_nxt = wcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state      <= CPU_PRI;
      wcnt       <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
`ifdef MEM_ARB_STATS_EN
      stat_stall <= '0;
      stat_dma   <= '0;
`endif
    end else begin
      wcnt <= wcnt_nxt;
      case (state)
        CPU_PRI:   if (wcnt_nxt == LIMIT) state <= DMA_FORCE;
        DMA_FORCE: if (!dma_req || dma_gnt) state <= CPU_PRI;
        default:   state <= CPU_PRI;
      endcase
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= ram_rdata;
      if (dma_gnt && !dma_we) dma_rdata <= ram_rdata;
`ifdef MEM_ARB_STATS_EN
      if (cpu_stall) stat_stall <= stat_stall + 32'd1;
      if (dma_gnt)   stat_dma   <= stat_dma + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small byte-addressed RAM model.
// Stats checks compile in only when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        CLR;
  logic        cpu_req, cpu_we, cpu_byte, cpu_half, cpu_uext;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_byte, dma_half, dma_uext;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_byte, ram_half, ram_uext;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_stall, stat_dma;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .CLR(CLR),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte(cpu_byte), .cpu_half(cpu_half), .cpu_uext(cpu_uext),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_byte(dma_byte), .dma_half(dma_half), .dma_uext(dma_uext),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_byte(ram_byte), .ram_half(ram_half), .ram_uext(ram_uext),
    .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_stall(stat_stall), .stat_dma(stat_dma)
`endif
  );

  // Little-endian byte RAM, combinational read with MIPS-style extension.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = ram_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    ram_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    if (ram_byte)
      ram_rdata = ram_uext ? {24'd0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
    else if (ram_half)
      ram_rdata = ram_uext ? {16'd0, mem[a1], mem[a0]} : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[a0] <= ram_wdata[7:0];
      if (!ram_byte) mem[a1] <= ram_wdata[15:8];
      if (!ram_byte && !ram_half) begin
        mem[a2] <= ram_wdata[23:16];
        mem[a3] <= ram_wdata[31:24];
      end
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic b, input logic h, input logic u);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cpu_byte = b; cpu_half = h; cpu_uext = u;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic b, input logic h, input logic u);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    dma_byte = b; dma_half = h; dma_uext = u;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    CLR = 1'b1;
    set_cpu(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    set_dma(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: cpu_gnt=%b dma_gnt=%b expected 0 0", cpu_gnt, dma_gnt);
    end
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ram_we: got %b expected 0", ram_we);
    end
    checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: rvalid=%b/%b rdata=%h/%h expected 0/0 0/0",
               cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
    end
    CLR = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_cpu_store_load;
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 32'h10) begin
      errors++;
      $display("FAIL cpu_store: gnt=%b stall=%b we=%b addr=%h expected 1 0 1 00000010",
               cpu_gnt, cpu_stall, ram_we, ram_addr);
    end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL store_no_rvalid: got %b expected 0", cpu_rvalid);
    end
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_load_gnt: gnt=%b stall=%b we=%b expected 1 0 0", cpu_gnt, cpu_stall, ram_we);
    end
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_load_data: rvalid=%b rdata=%h expected 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_rdata_hold: rvalid=%b rdata=%h expected 0 deadbeef", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_dma_byte_ext;
    set_dma(1'b1, 1'b1, 32'h11, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (dma_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h11) begin
      errors++;
      $display("FAIL dma_store: gnt=%b we=%b addr=%h expected 1 1 00000011", dma_gnt, ram_we, ram_addr);
    end
    tick();
    set_dma(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL dma_byte_sext: rvalid=%b rdata=%h expected 1 ffffff80", dma_rvalid, dma_rdata);
    end
    set_dma(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 1'b1);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL dma_byte_uext: rvalid=%b rdata=%h expected 1 00000080", dma_rvalid, dma_rdata);
    end
  endtask

  task automatic test_idle;
    tick();
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'd0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
      errors++;
      $display("FAIL idle_port: we=%b addr=%h gnt=%b/%b expected 0 00000000 0/0",
               ram_we, ram_addr, cpu_gnt, dma_gnt);
    end
    checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rvalid: rvalid=%b/%b expected 0/0", cpu_rvalid, dma_rvalid);
    end
  endtask

  // Both masters request every cycle; with limit 4 the DMA wins every fifth cycle.
  task automatic run_contention(input int n, input string tag);
    logic exp_cpu;
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    set_dma(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_cpu = ((i % 5) != 4);
      #1;
      checks++;
      if (cpu_gnt !== exp_cpu || dma_gnt !== !exp_cpu || cpu_stall !== !exp_cpu) begin
        errors++;
        $display("FAIL %s cycle %0d: cpu_gnt=%b dma_gnt=%b stall=%b expected %b %b %b",
                 tag, i, cpu_gnt, dma_gnt, cpu_stall, exp_cpu, !exp_cpu, !exp_cpu);
      end
      tick();
    end
  endtask

  task automatic test_starvation;
    run_contention(10, "starve");
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL starve_dma_read: rvalid=%b rdata=%h expected 1 00000080", dma_rvalid, dma_rdata);
    end
  endtask

  task automatic test_clr_midflight;
    for (int i = 0; i < 3; i++) tick();
    CLR = 1'b1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL clr_gnt: gnt=%b/%b we=%b expected 0/0 0", cpu_gnt, dma_gnt, ram_we);
    end
    tick();
    CLR = 1'b0;
    checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL clr_rvalid: rvalid=%b/%b expected 0/0", cpu_rvalid, dma_rvalid);
    end
    run_contention(5, "post_clr");
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checks++;
    if (stat_stall !== 32'd0 || stat_dma !== 32'd0) begin
      errors++;
      $display("FAIL stats_clr: stall=%0d dma=%0d expected 0 0", stat_stall, stat_dma);
    end
    run_contention(20, "stats_run");
    checks++;
    if (stat_dma !== 32'd4 || stat_stall !== 32'd4) begin
      errors++;
      $display("FAIL stats_count: dma=%0d stall=%0d expected 4 4", stat_dma, stat_stall);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_cpu_store_load();
    test_dma_byte_ext();
    test_idle();
    test_starvation();
    test_clr_midflight();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
